// File: rtl/uart_byte_receiver_pkg.sv
// uart_pkg: UART receiver state encodings, bit-timing helpers and the
// ASCII constants shared with the IFM/PBM message parser.
package uart_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam logic [7:0] ASCII_I    = 8'h49;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_B    = 8'h42;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// uart_byte_receiver_if: raw serial line in, received byte, strobes and busy out.
interface uart_byte_receiver_if;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       frame_err;
    logic       busy;
    modport master (output rx, input rx_msg, rx_complete, frame_err, busy);
    modport slave  (input rx, output rx_msg, rx_complete, frame_err, busy);
endinterface

// File: rtl/uart_byte_receiver_sync.sv
// uart_rx_sync: two-flop synchronizer for the rx line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);
    logic rx_meta;
    logic rx_prev;
    // resetting to 0 means a line held low through reset never looks like a start
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) {rx_meta, rx_s, rx_prev} <= 3'b000;
        else        {rx_meta, rx_s, rx_prev} <= {rx, rx_meta, rx_s};
    end
    assign start_edge = rx_prev & ~rx_s;
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with 3-sample majority voting,
// start-glitch rejection and framing-error reporting.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input logic                 clk_50M,
    input logic                 rst_n,
    uart_byte_receiver_if.slave bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF         = half_bit(CLKS_PER_BIT);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF);

    logic          rx_s;
    logic          start_edge;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic [1:0]    smp;
    logic [7:0]    rx_msg;
    logic          rx_complete;
    logic          frame_err;
    logic          bit_val;
    logic          decide;
    logic          last;

    uart_rx_sync u_sync (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .rx         (bus.rx),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    // smp holds the two previous synced samples, so the vote lands one cycle
    // earlier and the registered result appears at the mid-bit+1 count
    assign bit_val = majority3(smp[1], smp[0], rx_s);
    assign decide  = cnt == CNT_DECIDE;
    assign last    = cnt == CNT_LAST;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bitidx      <= '0;
            shreg       <= '0;
            smp         <= '0;
            rx_msg      <= '0;
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            smp         <= {smp[0], rx_s};
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
            cnt         <= (state == IDLE || state == WAIT_IDLE || last) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state  <= START;
                        bitidx <= '0;
                    end
                end
                START: begin
                    if (decide && bit_val) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decide) shreg[bitidx] <= bit_val;
                    if (last) begin
                        bitidx <= bitidx + 1'b1;
                        if (bitidx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // a good stop bit returns to IDLE mid-bit so back-to-back frames are caught
                    if (decide) begin
                        cnt         <= '0;
                        state       <= bit_val ? IDLE : WAIT_IDLE;
                        rx_msg      <= bit_val ? shreg : rx_msg;
                        rx_complete <= bit_val;
                        frame_err   <= ~bit_val;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_msg      = rx_msg;
    assign bus.rx_complete = rx_complete;
    assign bus.frame_err   = frame_err;
    assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: plans a whole line waveform, derives the expected
// per-cycle outputs from frame timing rules, then replays and compares.
module tb_uart_byte_receiver;
    localparam int CPB  = 50_000_000 / 115200;
    localparam int HALF = CPB / 2;
    localparam int NMAX = 90000;

    typedef struct {
        int         s;
        logic [7:0] b;
        int         kind;
        int         abort_at;
    } frame_t;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    uart_byte_receiver_if bus ();

    uart_byte_receiver dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    bit         wave   [NMAX];
    bit         rstw   [NMAX];
    bit         e_done [NMAX];
    bit         e_err  [NMAX];
    bit         e_busy [NMAX];
    logic [7:0] e_byte [NMAX];
    logic [7:0] e_msg  [NMAX];
    frame_t     frames [$];
    int         obs_cyc [$];
    logic [7:0] obs_byte [$];
    int         obs_err_cyc [$];
    int         checks = 0;
    int         errors = 0;
    int         ncyc;
    int         n_err_exp = 0;
    logic       busy_at_bound = 1'b1;

    function automatic void set_range(input int a, input int b, input bit v);
        for (int c = a; c < b; c++) wave[c] = v;
    endfunction

    function automatic void put_frame(input int s, input logic [7:0] b, input bit stop);
        set_range(s, s + CPB, 1'b0);
        for (int i = 0; i < 8; i++) set_range(s + (i + 1) * CPB, s + (i + 2) * CPB, b[i]);
        set_range(s + 9 * CPB, s + 10 * CPB, stop);
    endfunction

    function automatic void add(input int s, input logic [7:0] b, input int kind, input int abort_at);
        frame_t f;
        f.s = s; f.b = b; f.kind = kind; f.abort_at = abort_at;
        frames.push_back(f);
    endfunction

    function automatic void mark_busy(input int a, input int b);
        for (int c = a; c <= b; c++) e_busy[c] = 1'b1;
    endfunction

    // kinds: 0 good frame, 1 low stop bit, 2 start glitch only
    function automatic void build_expectations();
        logic [7:0] msg;
        int ev;
        int c;
        msg = 8'h00;
        foreach (frames[i]) begin
            ev = frames[i].s + 9 * CPB + HALF + 4;
            if (frames[i].kind == 2) mark_busy(frames[i].s + 3, frames[i].s + 3 + HALF);
            else if (frames[i].abort_at >= 0) mark_busy(frames[i].s + 3, frames[i].abort_at - 1);
            else if (frames[i].kind == 0) begin
                mark_busy(frames[i].s + 3, ev - 1);
                e_done[ev] = 1'b1;
                e_byte[ev] = frames[i].b;
            end else begin
                e_err[ev] = 1'b1;
                n_err_exp++;
                c = ev;
                while (!wave[c - 2]) c++;
                mark_busy(frames[i].s + 3, c);
            end
        end
        for (int k = 0; k < NMAX; k++) begin
            if (rstw[k]) msg = 8'h00;
            else if (e_done[k]) msg = e_byte[k];
            e_msg[k] = msg;
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    initial begin
        int p;
        int r;
        logic [7:0] ifm [4];
        logic [7:0] lit [8];
        logic [7:0] rb;
        bit stop;
        int gb;
        ifm = '{8'h49, 8'h46, 8'h4D, 8'h2D};
        lit = '{8'h49, 8'h49, 8'h46, 8'h4D, 8'h2D, 8'h54, 8'h55, 8'h42};
        bus.rx = 1'b1;
        for (int c = 0; c < NMAX; c++) wave[c] = 1'b1;
        for (int c = 0; c < 5; c++) rstw[c] = 1'b1;
        p = 20;
        put_frame(p, 8'h49, 1'b1); add(p, 8'h49, 0, -1); p += 10 * CPB + 200;
        for (int i = 0; i < 4; i++) begin
            put_frame(p, ifm[i], 1'b1); add(p, ifm[i], 0, -1); p += 10 * CPB;
        end
        p += 200;
        set_range(p, p + 100, 1'b0); add(p, 8'h00, 2, -1); p += 900;
        put_frame(p, 8'h53, 1'b0); set_range(p + 10 * CPB, p + 10 * CPB + 2000, 1'b0);
        add(p, 8'h53, 1, -1); p += 10 * CPB + 2050;
        put_frame(p, 8'h54, 1'b1); add(p, 8'h54, 0, -1); p += 10 * CPB + 200;
        put_frame(p, 8'h55, 1'b1); wave[p + 4 * CPB + HALF] = ~wave[p + 4 * CPB + HALF];
        add(p, 8'h55, 0, -1); p += 10 * CPB + 200;
        r = p + 5 * CPB + 100;
        set_range(p, p + CPB, 1'b0);
        rb = 8'h41;
        for (int i = 0; i < 4; i++) set_range(p + (i + 1) * CPB, p + (i + 2) * CPB, rb[i]);
        set_range(p + 5 * CPB, r + 305, 1'b0);
        for (int c = r; c < r + 5; c++) rstw[c] = 1'b1;
        add(p, 8'h41, 0, r); p = r + 305 + CPB + 50;
        put_frame(p, 8'h42, 1'b1); add(p, 8'h42, 0, -1); p += 10 * CPB + 200;
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            put_frame(p, rb, stop);
            gb = $urandom_range(1, 8);
            wave[p + gb * CPB + $urandom_range(0, CPB - 1)] ^= 1'b1;
            add(p, rb, stop ? 0 : 1, -1);
            if (stop) p += 10 * CPB + ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 300));
            else begin
                r = $urandom_range(0, 500);
                set_range(p + 10 * CPB, p + 10 * CPB + r, 1'b0);
                p += 10 * CPB + r + $urandom_range(5, 300);
            end
        end
        ncyc = p + 300;
        build_expectations();

        for (int c = 0; c < ncyc && errors < 50; c++) begin
            @(posedge clk_50M);
            #1;
            bus.rx = wave[c];
            rst_n  = ~rstw[c];
            @(negedge clk_50M);
            checks++;
            if ({bus.rx_complete, bus.frame_err, bus.busy, bus.rx_msg} !==
                {e_done[c], e_err[c], e_busy[c], e_msg[c]}) begin
                errors++;
                $display("FAIL cycle %0d outputs: got done=%b err=%b busy=%b msg=%h, expected done=%b err=%b busy=%b msg=%h",
                         c, bus.rx_complete, bus.frame_err, bus.busy, bus.rx_msg,
                         e_done[c], e_err[c], e_busy[c], e_msg[c]);
            end
            if (bus.rx_complete === 1'b1) begin
                obs_cyc.push_back(c);
                obs_byte.push_back(bus.rx_msg);
            end
            if (bus.frame_err === 1'b1) obs_err_cyc.push_back(c);
            if (c == 22120 + 2 + HALF + 3) busy_at_bound = bus.busy;
        end

        check("pulse count at least 8", obs_cyc.size() >= 8 ? 1 : 0, 1);
        for (int i = 0; i < 8; i++)
            if (i < obs_byte.size()) check($sformatf("directed byte %0d", i), int'(obs_byte[i]), int'(lit[i]));
        if (obs_cyc.size() >= 3) begin
            check("first rx_complete cycle", obs_cyc[0], 4147);
            check("back-to-back spacing", obs_cyc[2] - obs_cyc[1], 4340);
        end
        check("frame_err pulse count", obs_err_cyc.size(), n_err_exp);
        if (obs_err_cyc.size() >= 1) check("first frame_err cycle", obs_err_cyc[0], 27147);
        check("busy low after glitch", int'(busy_at_bound), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
